// File: rtl/lock_detect.sv
// Phase/frequency lock detector: pairs fb/vco rising edges, reports phase error per hit,
// and tracks lock with hit/miss hysteresis plus a no-signal watchdog on fb.
module lock_detect #(
   parameter int unsigned WINDOW        = 16,
   parameter int unsigned LOCK_HITS     = 64,
   parameter int unsigned UNLOCK_MISSES = 4,
   parameter int unsigned NOSIG_CYCLES  = 2000
) (
   input  logic       clk_50,
   input  logic       rst_n,
   input  logic       fb,
   input  logic       vco,
   output logic       locked,
   output logic       nosig,
   output logic [7:0] phase_err,
   output logic       err_valid
);

   localparam logic [7:0]  WIN_C = 8'(WINDOW);
   localparam logic [7:0]  LH_C  = 8'(LOCK_HITS);
   localparam logic [3:0]  UM_C  = 4'(UNLOCK_MISSES);
   localparam logic [15:0] NS_C  = 16'(NOSIG_CYCLES);

   typedef enum logic [1:0] {P_IDLE = 2'd0, P_WAIT_VCO = 2'd1, P_WAIT_FB = 2'd2} pair_t;
   typedef enum logic [1:0] {L_UNLOCKED = 2'd0, L_ACQUIRING = 2'd1, L_LOCKED = 2'd2} lock_t;

   pair_t       pair_q, pair_d;
   lock_t       lock_q, lock_d;
   logic [7:0]  pcnt_q, pcnt_d;
   logic [7:0]  hcnt_q, hcnt_d;
   logic [3:0]  mcnt_q, mcnt_d;
   logic [15:0] nscnt_q, nscnt_d;
   logic        fb_q, vco_q;
   logic        locked_q, nosig_q, err_valid_q;
   logic [7:0]  phase_err_q, phase_d;
   logic        fb_rise_s, vco_rise_s, hit_s, miss_s;
   logic [7:0]  hinc_s;
   logic [3:0]  minc_s;

   assign fb_rise_s  = fb & ~fb_q;
   assign vco_rise_s = vco & ~vco_q;
   assign hinc_s     = (hcnt_q == 8'hFF) ? hcnt_q : (hcnt_q + 8'd1);
   assign minc_s     = (mcnt_q == 4'hF) ? mcnt_q : (mcnt_q + 4'd1);

   // Edge pairing: a repeated edge on the waiting side is a miss and restarts the pair
   always_comb begin
      pair_d  = pair_q;
      pcnt_d  = pcnt_q;
      hit_s   = 1'b0;
      miss_s  = 1'b0;
      phase_d = phase_err_q;
      if (nosig_q) begin
         pair_d = P_IDLE;
         pcnt_d = 8'd0;
      end else begin
         case (pair_q)
            P_IDLE: begin
               if (fb_rise_s && vco_rise_s) begin
                  hit_s   = 1'b1;
                  phase_d = 8'd0;
               end else if (fb_rise_s) begin
                  pair_d = P_WAIT_VCO;
                  pcnt_d = 8'd1;
               end else if (vco_rise_s) begin
                  pair_d = P_WAIT_FB;
                  pcnt_d = 8'd1;
               end else begin
                  pcnt_d = 8'd0;
               end
            end
            P_WAIT_VCO: begin
               if (fb_rise_s) begin
                  miss_s = 1'b1;
                  pcnt_d = 8'd1;
               end else if (vco_rise_s) begin
                  hit_s   = 1'b1;
                  phase_d = pcnt_q;
                  pair_d  = P_IDLE;
                  pcnt_d  = 8'd0;
               end else if (pcnt_q >= WIN_C) begin
                  miss_s = 1'b1;
                  pair_d = P_IDLE;
                  pcnt_d = 8'd0;
               end else begin
                  pcnt_d = pcnt_q + 8'd1;
               end
            end
            P_WAIT_FB: begin
               if (vco_rise_s) begin
                  miss_s = 1'b1;
                  pcnt_d = 8'd1;
               end else if (fb_rise_s) begin
                  hit_s   = 1'b1;
                  phase_d = 8'd0 - pcnt_q;
                  pair_d  = P_IDLE;
                  pcnt_d  = 8'd0;
               end else if (pcnt_q >= WIN_C) begin
                  miss_s = 1'b1;
                  pair_d = P_IDLE;
                  pcnt_d = 8'd0;
               end else begin
                  pcnt_d = pcnt_q + 8'd1;
               end
            end
            default: begin
               pair_d = P_IDLE;
               pcnt_d = 8'd0;
            end
         endcase
      end
   end

   // Lock hysteresis; a lost fb signal forces everything back to unlocked
   always_comb begin
      lock_d = lock_q;
      hcnt_d = hcnt_q;
      mcnt_d = mcnt_q;
      if (nosig_q) begin
         lock_d = L_UNLOCKED;
         hcnt_d = 8'd0;
         mcnt_d = 4'd0;
      end else begin
         case (lock_q)
            L_UNLOCKED: begin
               if (hit_s) begin
                  hcnt_d = 8'd1;
                  mcnt_d = 4'd0;
                  lock_d = (LH_C <= 8'd1) ? L_LOCKED : L_ACQUIRING;
               end else begin
                  hcnt_d = 8'd0;
               end
            end
            L_ACQUIRING: begin
               if (hit_s) begin
                  hcnt_d = hinc_s;
                  if (hinc_s >= LH_C) begin
                     lock_d = L_LOCKED;
                     mcnt_d = 4'd0;
                  end else begin
                     lock_d = L_ACQUIRING;
                  end
               end else if (miss_s) begin
                  lock_d = L_UNLOCKED;
                  hcnt_d = 8'd0;
               end else begin
                  lock_d = L_ACQUIRING;
               end
            end
            L_LOCKED: begin
               if (hit_s) begin
                  mcnt_d = 4'd0;
               end else if (miss_s) begin
                  if (minc_s >= UM_C) begin
                     lock_d = L_UNLOCKED;
                     hcnt_d = 8'd0;
                     mcnt_d = 4'd0;
                  end else begin
                     mcnt_d = minc_s;
                  end
               end else begin
                  mcnt_d = mcnt_q;
               end
            end
            default: begin
               lock_d = L_UNLOCKED;
               hcnt_d = 8'd0;
               mcnt_d = 4'd0;
            end
         endcase
      end
   end

   // No-signal watchdog: saturating count of cycles since the last fb edge
   always_comb begin
      if (fb_rise_s) begin
         nscnt_d = 16'd0;
      end else if (nscnt_q < NS_C) begin
         nscnt_d = nscnt_q + 16'd1;
      end else begin
         nscnt_d = nscnt_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         fb_q        <= 1'b0;
         vco_q       <= 1'b0;
         pair_q      <= P_IDLE;
         lock_q      <= L_UNLOCKED;
         pcnt_q      <= 8'd0;
         hcnt_q      <= 8'd0;
         mcnt_q      <= 4'd0;
         nscnt_q     <= 16'd0;
         locked_q    <= 1'b0;
         nosig_q     <= 1'b0;
         err_valid_q <= 1'b0;
         phase_err_q <= 8'd0;
      end else begin
         fb_q        <= fb;
         vco_q       <= vco;
         pair_q      <= pair_d;
         lock_q      <= lock_d;
         pcnt_q      <= pcnt_d;
         hcnt_q      <= hcnt_d;
         mcnt_q      <= mcnt_d;
         nscnt_q     <= nscnt_d;
         locked_q    <= (lock_d == L_LOCKED);
         nosig_q     <= (nscnt_d == NS_C);
         err_valid_q <= hit_s;
         phase_err_q <= phase_d;
      end
   end

   assign locked    = locked_q;
   assign nosig     = nosig_q;
   assign err_valid = err_valid_q;
   assign phase_err = phase_err_q;

endmodule

// File: doc/lock_detect.md
LOCK_DETECT -- requirements
Module: lock_detect

Interface
REQ-001 SHALL have parameter WINDOW, default 16: max clk_50 cycles between paired fb/vco rising edges that count as a hit (1..255).
REQ-002 SHALL have parameter LOCK_HITS, default 64: consecutive hits required to declare lock (1..255).
REQ-003 SHALL have parameter UNLOCK_MISSES, default 4: consecutive misses required to drop lock (1..15).
REQ-004 SHALL have parameter NOSIG_CYCLES, default 2000: cycles without any fb edge before nosig asserts (1..65535).
REQ-005 clk_50  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 fb  input  1  feedback signal, already two-flop synchronized to clk_50.
REQ-008 vco  input  1  delayed VCO output, synchronous to clk_50.
REQ-009 locked  output  1  high while lock FSM is in LOCKED.
REQ-010 nosig  output  1  high while fb has shown no rising edge for NOSIG_CYCLES cycles.
REQ-011 phase_err  output  8  signed two's-complement cycles from fb edge to vco edge of the last hit; positive = fb leads.
REQ-012 err_valid  output  1  one-cycle strobe, phase_err updated this cycle.

Function
REQ-013 Edge detect: rising edge = input high and its one-cycle-delayed copy low; delay registers reset to 0.
REQ-014 Pair FSM states IDLE, WAIT_VCO, WAIT_FB; 8-bit counter pcnt.
REQ-015 IDLE: fb edge only -> WAIT_VCO, pcnt=1; vco edge only -> WAIT_FB, pcnt=1; both same cycle -> hit with phase_err=0, stay IDLE.
REQ-016 WAIT_VCO: vco edge -> hit, phase_err=+pcnt, IDLE; else pcnt increments.
REQ-017 WAIT_FB: fb edge -> hit, phase_err=-pcnt, IDLE; else pcnt increments.
REQ-018 In WAIT_x, pcnt reaching WINDOW with no partner edge -> miss, IDLE; phase_err unchanged, err_valid low.
REQ-019 In WAIT_VCO, a second fb edge before the vco edge -> miss, restart WAIT_VCO with pcnt=1 (symmetric for WAIT_FB); a miss takes precedence over a partner edge arriving the same cycle.
REQ-020 err_valid SHALL pulse exactly the cycle after a hit is decided, together with the new phase_err.
REQ-021 Lock FSM states UNLOCKED, ACQUIRING, LOCKED; hit counter hcnt (8-bit, saturating), miss counter mcnt (4-bit, saturating).
REQ-022 UNLOCKED: hit -> ACQUIRING, hcnt=1.
REQ-023 ACQUIRING: hit -> hcnt+1, and hcnt reaching LOCK_HITS -> LOCKED, mcnt=0; miss -> UNLOCKED, hcnt=0.
REQ-024 LOCKED: hit -> mcnt=0; miss -> mcnt+1, and mcnt reaching UNLOCK_MISSES -> UNLOCKED, hcnt=0.
REQ-025 nosig: 16-bit counter cleared on any fb rising edge, increments otherwise, saturates at NOSIG_CYCLES; nosig = (counter == NOSIG_CYCLES).
REQ-026 While nosig high, lock FSM SHALL be forced to UNLOCKED and pair FSM to IDLE; hits are ignored until the next fb edge clears nosig.
REQ-027 locked and nosig SHALL be registered outputs with no combinational path from fb or vco.
REQ-028 With LOCK_HITS=1, the first hit from UNLOCKED SHALL go to LOCKED in one transition.

Reset
REQ-029 rst_n low SHALL immediately clear: locked=0, nosig=0, phase_err=0, err_valid=0, both FSMs to IDLE/UNLOCKED, all counters 0, edge-delay registers 0.
REQ-030 Deassertion SHALL need no synchronizer inside this block; first edge detection is permitted on the second clk_50 after release.
REQ-031 Reset asserted mid-pair or mid-acquire SHALL discard pending state with no err_valid pulse.

Verification
REQ-032 fb and vco 400-cycle square waves, vco lagging 5 cycles -> err_valid every 400 cycles, phase_err=+5, locked rises after the 64th hit.
REQ-033 While locked, vco lags 20 cycles (> WINDOW) -> misses; locked falls after the 4th consecutive miss; 3 misses then a hit keeps locked.
REQ-034 Simultaneous fb/vco edges -> phase_err=0, err_valid pulse, counts as a hit.
REQ-035 vco leading fb by 7 cycles -> phase_err=8'hF9 (-7).
REQ-036 fb held low 2000 cycles while locked -> nosig=1, locked=0; next fb edge -> nosig=0 the following cycle.
REQ-037 rst_n pulsed low while in WAIT_VCO with hcnt=30 -> all outputs 0 at once; re-acquisition needs a full 64 hits.
